// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: default widths,
// read-owner encoding and the grant/read-tag types.
package dmem_pkg;

    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_ADDR_W = 12;
    localparam int CNT_W       = 8;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_AUX  = 1'b1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CORE = 2'd1,
        GNT_AUX  = 2'd2
    } grant_e;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

endpackage

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// Read-tag delay line: carries {valid, owner} of each granted read
// for RD_LAT clocks so it lines up with the RAM read data.
//   clk_i, rst_ni : clock, async active-low reset
//   tag_i         : tag of the read issued this cycle
//   tag_o         : tag whose data is on the RAM output this cycle
module rd_tag_pipe
    import dmem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t [RD_LAT-1:0] tag_q;
    rd_tag_t [RD_LAT-1:0] tag_d;

    always_comb begin
        tag_d    = tag_q;
        tag_d[0] = tag_i;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag_o = tag_q[RD_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: core has fixed priority, aux port gets
// one forced slot after MAX_WAIT consecutive denied cycles.
//   clock, reset          : core clock, async active-low reset
//   core_*                : core data bus (core_stall freezes the core)
//   aux_*                 : auxiliary requester, req held until aux_ack
//   mem_*                 : RAM macro port (RD_LAT read latency)
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int MAX_WAIT = 8,
    parameter int RD_LAT   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [15:0]       core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [15:0]       aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_ack,
    output logic              aux_rvalid,
    output logic [DATA_W-1:0] aux_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              force_q, force_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] ardata_q, ardata_d;
    grant_e            gnt;
    rd_tag_t           push_tag, pop_tag;

    // Only the low ADDR_W address bits reach the RAM.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{core_addr[15:ADDR_W], aux_addr[15:ADDR_W]};

    // Grant decision; reset masks all grants so nothing leaks to the RAM.
    always_comb begin
        gnt = GNT_NONE;
        if (!reset) begin
            gnt = GNT_NONE;
        end else if (force_q && aux_req) begin
            gnt = GNT_AUX;
        end else if (core_req) begin
            gnt = GNT_CORE;
        end else if (aux_req) begin
            gnt = GNT_AUX;
        end
    end

    // RAM port mux; the address holds its last value when idle.
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        aux_ack   = 1'b0;
        unique case (gnt)
            GNT_CORE: begin
                mem_addr  = core_addr[ADDR_W-1:0];
                mem_wdata = core_wdata;
                mem_wren  = core_we;
            end
            GNT_AUX: begin
                mem_addr  = aux_addr[ADDR_W-1:0];
                mem_wdata = aux_wdata;
                mem_wren  = aux_we;
                aux_ack   = 1'b1;
            end
            default: ;
        endcase
        addr_d = mem_addr;
    end

    // An aux grant while the core is requesting is only possible
    // in a forced slot, so this is exactly the forced-stall case.
    assign core_stall = (gnt == GNT_AUX) && core_req;

    // Starvation counter: force rises on the edge the count hits MAX.
    always_comb begin
        wait_cnt_d = '0;
        force_d    = 1'b0;
        if (aux_req && (gnt != GNT_AUX)) begin
            if (wait_cnt_q >= MAX_CNT) begin
                wait_cnt_d = MAX_CNT;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
            force_d = (wait_cnt_d == MAX_CNT);
        end
    end

    always_comb begin
        push_tag.valid = (gnt != GNT_NONE) && !mem_wren;
        push_tag.owner = (gnt == GNT_AUX) ? OWN_AUX : OWN_CORE;
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk_i  (clock),
        .rst_ni (reset),
        .tag_i  (push_tag),
        .tag_o  (pop_tag)
    );

    // Aux data is presented straight from the RAM in its return cycle
    // and held afterwards until the next aux read returns.
    assign aux_rvalid = pop_tag.valid && (pop_tag.owner == OWN_AUX);
    assign aux_rdata  = aux_rvalid ? mem_rdata : ardata_q;
    assign ardata_d   = aux_rdata;
    assign core_rdata = mem_rdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
            force_q    <= 1'b0;
            addr_q     <= '0;
            ardata_q   <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            force_q    <= force_d;
            addr_q     <= addr_d;
            ardata_q   <= ardata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a RAM model and a
// cycle-level reference model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int DW  = 16;
    localparam int AW  = 12;
    localparam int MW  = 8;
    localparam int LAT = 2;

    logic          clk;
    logic          reset;
    logic          core_req, core_we;
    logic [15:0]   core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic          core_stall;
    logic          aux_req, aux_we;
    logic [15:0]   aux_addr;
    logic [DW-1:0] aux_wdata;
    logic          aux_ack, aux_rvalid;
    logic [DW-1:0] aux_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_wren;

    int vectors = 0;
    int miscompares = 0;

    dmem_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW), .RD_LAT(LAT)
    ) dut (
        .clock(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .aux_req(aux_req), .aux_we(aux_we),
        .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_ack(aux_ack), .aux_rvalid(aux_rvalid),
        .aux_rdata(aux_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wren(mem_wren), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM macro model with LAT-cycle read latency
    logic [DW-1:0] ram [1<<AW];
    logic [DW-1:0] rp  [LAT];

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
        for (int i = 0; i < LAT; i++) rp[i] = '0;
    end

    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_wdata;
        rp[0] <= ram[mem_addr];
        for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
    end

    assign mem_rdata = rp[LAT-1];

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Reference model
    int            cyc = 0;
    int            streak = 0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_ard = '0;
    logic [DW-1:0] shadow [1<<AW];
    int            aq_due[$];
    logic [DW-1:0] aq_dat[$];
    int            cq_due[$];
    logic [DW-1:0] cq_dat[$];
    bit            m_forced, m_ga, m_gc, m_ev, m_we;
    logic [AW-1:0] m_ea;
    logic [DW-1:0] m_wd, m_tmp;
    int            m_tmpi;

    initial for (int i = 0; i < (1 << AW); i++) shadow[i] = '0;

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_ack", aux_ack, 0);
            chk("rst_stall", core_stall, 0);
            chk("rst_wren", mem_wren, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_wdata", mem_wdata, 0);
            chk("rst_rvalid", aux_rvalid, 0);
            chk("rst_ardata", aux_rdata, 0);
            streak = 0;
            last_addr = '0;
            last_ard = '0;
            aq_due.delete(); aq_dat.delete();
            cq_due.delete(); cq_dat.delete();
        end else begin
            m_forced = (streak >= MW);
            m_ga = aux_req && (m_forced || !core_req);
            m_gc = core_req && !m_ga;
            m_ea = m_ga ? aux_addr[AW-1:0] :
                   m_gc ? core_addr[AW-1:0] : last_addr;
            m_we = m_ga ? aux_we : (m_gc ? core_we : 1'b0);
            m_wd = m_ga ? aux_wdata : core_wdata;
            chk("ack", aux_ack, m_ga);
            chk("stall", core_stall, m_ga && core_req);
            chk("addr", mem_addr, m_ea);
            chk("wren", mem_wren, m_we);
            if (m_we) chk("wdata", mem_wdata, m_wd);
            m_ev = (aq_due.size() > 0) && (aq_due[0] == cyc);
            if (m_ev) begin
                last_ard = aq_dat.pop_front();
                m_tmpi = aq_due.pop_front();
            end
            chk("rvalid", aux_rvalid, m_ev);
            chk("ardata", aux_rdata, last_ard);
            if (cq_due.size() > 0 && cq_due[0] == cyc) begin
                m_tmp = cq_dat.pop_front();
                m_tmpi = cq_due.pop_front();
                chk("crdata", core_rdata, m_tmp);
            end
            if (m_ga || m_gc) begin
                last_addr = m_ea;
                if (m_we) begin
                    shadow[m_ea] = m_wd;
                end else if (m_ga) begin
                    aq_due.push_back(cyc + LAT);
                    aq_dat.push_back(shadow[m_ea]);
                end else begin
                    cq_due.push_back(cyc + LAT);
                    cq_dat.push_back(shadow[m_ea]);
                end
            end
            if (aux_req && !m_ga)
                streak = (streak < MW) ? streak + 1 : streak;
            else
                streak = 0;
        end
        cyc++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic probe;
        @(negedge clk);
        #1;
    endtask

    task automatic drv_core(logic r, logic w, logic [15:0] a, logic [15:0] d);
        core_req = r; core_we = w; core_addr = a; core_wdata = d;
    endtask

    task automatic drv_aux(logic r, logic w, logic [15:0] a, logic [15:0] d);
        aux_req = r; aux_we = w; aux_addr = a; aux_wdata = d;
    endtask

    int n;

    initial begin
        reset = 1'b0;
        drv_core(0, 0, 16'h0, 16'h0);
        drv_aux(0, 0, 16'h0, 16'h0);

        // reset held while requests toggle
        for (int i = 0; i < 4; i++) begin
            drv_core(i[0], 1, 16'h0ABC, 16'h1234);
            drv_aux(!i[0], 1, 16'h0DEF, 16'h5678);
            probe();
            chk("lit_rst_ack", aux_ack, 0);
            chk("lit_rst_wren", mem_wren, 0);
            chk("lit_rst_addr", mem_addr, 0);
            tick();
        end

        // release, core read of 0x0010
        reset = 1'b1;
        drv_core(1, 0, 16'h0010, 16'h0);
        drv_aux(0, 0, 16'h0, 16'h0);
        probe();
        chk("lit_c_addr", mem_addr, 12'h010);
        chk("lit_c_ack", aux_ack, 0);
        chk("lit_c_stall", core_stall, 0);
        tick();

        // aux write then aux read of 0x123
        drv_core(0, 0, 16'h0, 16'h0);
        drv_aux(1, 1, 16'h0123, 16'hBEEF);
        probe();
        chk("lit_aw_ack", aux_ack, 1);
        chk("lit_aw_wren", mem_wren, 1);
        chk("lit_aw_addr", mem_addr, 12'h123);
        tick();
        drv_aux(0, 0, 16'h0, 16'h0);
        tick();
        drv_aux(1, 0, 16'h0123, 16'h0);
        probe();
        chk("lit_ar_ack", aux_ack, 1);
        tick();
        drv_aux(0, 0, 16'h0, 16'h0);
        probe();
        chk("lit_ar_early", aux_rvalid, 0);
        tick();
        probe();
        chk("lit_ar_valid", aux_rvalid, 1);
        chk("lit_ar_data", aux_rdata, 16'hBEEF);
        tick();
        probe();
        chk("lit_ar_once", aux_rvalid, 0);
        chk("lit_ar_hold", aux_rdata, 16'hBEEF);
        tick();

        // constant contention: 8 denials then forced slot
        drv_core(1, 0, 16'h0050, 16'h0);
        drv_aux(1, 0, 16'h0200, 16'h0);
        for (int i = 0; i < MW; i++) begin
            probe();
            chk("lit_deny", aux_ack, 0);
            tick();
        end
        probe();
        chk("lit_f_ack", aux_ack, 1);
        chk("lit_f_stall", core_stall, 1);
        chk("lit_f_addr", mem_addr, 12'h200);
        tick();
        probe();
        chk("lit_post_ack", aux_ack, 0);
        chk("lit_post_stall", core_stall, 0);
        chk("lit_post_addr", mem_addr, 12'h050);
        tick();
        drv_core(0, 0, 16'h0, 16'h0);
        drv_aux(0, 0, 16'h0, 16'h0);
        tick();

        // aux drops after 5 denials, then re-raises
        drv_core(1, 0, 16'h0060, 16'h0);
        drv_aux(1, 0, 16'h0300, 16'h0);
        for (int i = 0; i < 5; i++) tick();
        aux_req = 1'b0;
        tick();
        aux_req = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            probe();
            if (aux_ack) break;
            n++;
            @(posedge clk);
            #1;
        end
        chk("lit_reraise_wait", n, MW);
        tick();
        drv_core(0, 0, 16'h0, 16'h0);
        drv_aux(0, 0, 16'h0, 16'h0);
        tick();

        // core read 0x020 then aux read 0x021, no cross-delivery
        drv_core(1, 1, 16'h0020, 16'h1111);
        tick();
        drv_core(1, 1, 16'h0021, 16'h2222);
        tick();
        drv_core(1, 0, 16'hF020, 16'h0);
        probe();
        chk("lit_trunc", mem_addr, 12'h020);
        tick();
        drv_core(0, 0, 16'h0, 16'h0);
        drv_aux(1, 0, 16'h0021, 16'h0);
        probe();
        chk("lit_x_ack", aux_ack, 1);
        tick();
        drv_aux(0, 0, 16'h0, 16'h0);
        probe();
        chk("lit_x_crd", core_rdata, 16'h1111);
        chk("lit_x_noval", aux_rvalid, 0);
        tick();
        probe();
        chk("lit_x_val", aux_rvalid, 1);
        chk("lit_x_ard", aux_rdata, 16'h2222);
        tick();

        // reset one cycle after an aux read grant
        drv_aux(1, 0, 16'h0123, 16'h0);
        probe();
        chk("lit_m_ack", aux_ack, 1);
        tick();
        reset = 1'b0;
        drv_aux(0, 0, 16'h0, 16'h0);
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            probe();
            chk("lit_m_noval", aux_rvalid, 0);
            tick();
        end
        drv_core(1, 0, 16'h0070, 16'h0);
        drv_aux(1, 0, 16'h0400, 16'h0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            probe();
            if (aux_ack) break;
            n++;
            @(posedge clk);
            #1;
        end
        chk("lit_m_wait", n, MW);
        tick();
        drv_core(0, 0, 16'h0, 16'h0);
        drv_aux(0, 0, 16'h0, 16'h0);
        tick();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

endmodule
